mux_nto1_rr_arbiter: RTL and testbench
======================================

# mux_Nto1_rr_arbiter

Round-robin, packet-locking arbiter that shares one N-to-1 mux datapath among SIZE requesters. It selects one requester, holds the grant until that requester's last flit is accepted, and drives the mux with a one-hot grant. The selected flit is captured in a single valid/ready output register. The block sits between per-port input queues and a shared downstream resource such as a router output port or a link.

## Interface
- WIDTH, 4, flit data width in bits.
- SIZE, 8, number of requesters (≥2).
- LOG_SIZE, ceil(log2(SIZE)), width of `out_src`; localparam.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- req  in  SIZE  bit i: requester i presents a valid flit.
- req_last  in  SIZE  bit i: requester i's current flit is its packet tail; qualified by req[i].
- in  in  WIDTH*SIZE  flit data; requester i occupies bits [WIDTH*i +: WIDTH].
- ack  out  SIZE  one-hot or zero; ack[i]=1 means requester i's flit is consumed this cycle.
- grant  out  SIZE  registered one-hot grant, or zero when idle; also drives the decoded mux select.
- out  out  WIDTH  registered flit data.
- out_last  out  1  registered tail flag.
- out_src  out  LOG_SIZE  encoded index of the requester that produced `out`.
- out_valid  out  1  `out`, `out_last` and `out_src` are valid.
- out_ready  in  1  downstream accepts the output flit when it is high together with out_valid.

## Operation
- Datapath: `out` is the decoded N-to-1 mux of `in`, selected by `grant`, then registered.
- State: `grant` (SIZE bits), round-robin pointer `ptr` (LOG_SIZE bits), output register (`out`, `out_last`, `out_src`, `out_valid`).
- Lock state is implicit: IDLE when grant==0, LOCKED otherwise.
- Define can_accept = ~out_valid | out_ready.
- IDLE:
  - If req != 0, grant is set next cycle to the first requester with req set, scanning ptr, ptr+1, …, SIZE-1, 0, … (wrap-around).
  - No ack is asserted in IDLE.
- LOCKED on requester g:
  - ack[g] = grant[g] & req[g] & can_accept (combinational).
  - When ack[g] is high, the output register loads in[g], req_last[g] and g, and out_valid sets.
  - When ack[g] & req_last[g]: next cycle grant clears and ptr becomes (g+1) mod SIZE.
  - Requests from other requesters are ignored while locked.
  - If req[g] drops mid-packet, the lock holds and no transfer occurs.
- Output register:
  - If out_valid & out_ready and there is no new ack, out_valid clears.
  - If out_valid & ~out_ready, all output fields hold.
- Reset values: grant=0, ack=0, ptr=0, out_valid=0, out=0, out_last=0, out_src=0.
- Reset mid-packet abandons the packet with no flush; the requester must restart the packet.
- Invariant: at most one ack bit high per cycle; ack is a subset of grant.

## Timing
- Arbitration latency: req rises in cycle 0 with the block idle → grant in cycle 1 → ack in cycle 1 if can_accept → out_valid in cycle 2.
- Throughput inside a packet: one flit per cycle while req[g] and out_ready stay high.
- Re-arbitration bubble: exactly one idle cycle (grant=0) after each tail is accepted.
- Back-to-back single-flit packets from different requesters therefore sustain one flit every 2 cycles.
- Backpressure: ack depends combinationally on out_ready. There is no combinational path from req to out.

## Test plan
- Reset and idle: assert reset with all req high → after release, grant=0, ptr=0, out_valid=0; first grant lands one cycle later on requester 0.
- Round-robin fairness: SIZE=8, all req high, every req_last=1, out_ready=1 → out_src sequence 0,1,2,…,7,0 with one flit every 2 cycles; ack never multi-hot.
- Packet lock: requester 3 sends a 4-flit packet (req_last on the 4th flit) while requester 5 also requests → four consecutive out_src=3 flits, grant bubble, then requester 5 granted; ptr=4 after the tail.
- Backpressure: out_ready=0 for 3 cycles mid-packet → out and out_last held stable, ack=0, no flit lost or duplicated; transfer resumes on the cycle out_ready returns high.
- Wrap-around and gaps: ptr=6, only req[2] and req[7] high → grant 7, then 2; with a gap in req[g] mid-packet, the lock holds and no ack is issued.
- Reset mid-operation: assert reset during the 2nd flit of a locked packet → next cycle grant=0, ack=0, out_valid=0, ptr=0.

Source files
------------

// File: rtl/mux_nto1_rr_arbiter.sv
// Round-robin, packet-locking N-to-1 arbiter with a one-hot grant driving a decoded mux
// and a single valid/ready output register.
module mux_nto1_rr_arbiter #(
    parameter  int WIDTH    = 4,
    parameter  int SIZE     = 8,
    localparam int LOG_SIZE = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SIZE-1:0]       req,
    input  logic [SIZE-1:0]       req_last,
    input  logic [WIDTH*SIZE-1:0] in,
    output logic [SIZE-1:0]       ack,
    output logic [SIZE-1:0]       grant,
    output logic [WIDTH-1:0]      out,
    output logic                  out_last,
    output logic [LOG_SIZE-1:0]   out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SIZE-1:0]     grant_r;
    logic [SIZE-1:0]     grant_nxt_s;
    logic [SIZE-1:0]     ack_s;
    logic [LOG_SIZE-1:0] ptr_r;
    logic [LOG_SIZE-1:0] ptr_nxt_s;
    logic [LOG_SIZE-1:0] grant_idx_s;
    logic [LOG_SIZE-1:0] pick_idx_s;
    logic [LOG_SIZE-1:0] scan_idx_s;
    logic                pick_found_s;
    logic                can_accept_s;
    logic                tail_ack_s;
    logic                load_s;
    logic [WIDTH-1:0]    mux_data_s;
    logic                mux_last_s;
    logic [WIDTH-1:0]    out_r;
    logic                out_last_r;
    logic [LOG_SIZE-1:0] out_src_r;
    logic                out_valid_r;

    // Decoded AND-OR mux and one-hot to index encoding, both steered by the registered grant.
    always_comb begin
        mux_data_s  = {WIDTH{1'b0}};
        mux_last_s  = 1'b0;
        grant_idx_s = {LOG_SIZE{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            mux_data_s  = mux_data_s | (in[WIDTH*i +: WIDTH] & {WIDTH{grant_r[i]}});
            mux_last_s  = mux_last_s | (req_last[i] & grant_r[i]);
            grant_idx_s = grant_idx_s | (LOG_SIZE'(i) & {LOG_SIZE{grant_r[i]}});
        end
    end

    // Round-robin search: first request found scanning ptr, ptr+1, ... with wrap-around.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = ptr_r;
        scan_idx_s   = ptr_r;
        for (int k = 0; k < SIZE; k++) begin
            scan_idx_s   = LOG_SIZE'((int'(ptr_r) + k) % SIZE);
            pick_idx_s   = (!pick_found_s && req[scan_idx_s]) ? scan_idx_s : pick_idx_s;
            pick_found_s = pick_found_s | req[scan_idx_s];
        end
    end

    // Handshake and lock control; the lock is released only by an accepted tail flit.
    always_comb begin
        can_accept_s = ~out_valid_r | out_ready;
        ack_s        = grant_r & req & {SIZE{can_accept_s}};
        tail_ack_s   = |(ack_s & req_last);
        load_s       = |ack_s;
        grant_nxt_s  = grant_r;
        ptr_nxt_s    = ptr_r;
        if (grant_r == {SIZE{1'b0}}) begin
            if (pick_found_s) begin
                grant_nxt_s = SIZE'(1'b1) << pick_idx_s;
            end else begin
                grant_nxt_s = {SIZE{1'b0}};
            end
        end else if (tail_ack_s) begin
            grant_nxt_s = {SIZE{1'b0}};
            ptr_nxt_s   = (grant_idx_s == LOG_SIZE'(SIZE - 1)) ? {LOG_SIZE{1'b0}}
                                                               : grant_idx_s + LOG_SIZE'(1'b1);
        end else begin
            grant_nxt_s = grant_r;
        end
    end

    // Grant and round-robin pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_r <= {SIZE{1'b0}};
            ptr_r   <= {LOG_SIZE{1'b0}};
        end else begin
            grant_r <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Output register: loads on ack, drains on out_ready, otherwise holds under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_r       <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            out_src_r   <= {LOG_SIZE{1'b0}};
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_r       <= mux_data_s;
            out_last_r  <= mux_last_s;
            out_src_r   <= grant_idx_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign ack       = ack_s;
    assign grant     = grant_r;
    assign out       = out_r;
    assign out_last  = out_last_r;
    assign out_src   = out_src_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_nto1_rr_arbiter.sv
// Directed bench for mux_nto1_rr_arbiter: per-requester flit sources feed the DUT and an
// independent monitor checks every accepted output flit against a queue of expected flits.
module tb_mux_nto1_rr_arbiter;

    localparam int WIDTH    = 4;
    localparam int SIZE     = 8;
    localparam int LOG_SIZE = $clog2(SIZE);
    localparam int DEPTH    = 32;

    typedef logic [LOG_SIZE+WIDTH:0] exp_t;

    logic                  clock;
    logic                  reset;
    logic [SIZE-1:0]       req;
    logic [SIZE-1:0]       req_last;
    logic [WIDTH*SIZE-1:0] in;
    logic [SIZE-1:0]       ack;
    logic [SIZE-1:0]       grant;
    logic [WIDTH-1:0]      out;
    logic                  out_last;
    logic [LOG_SIZE-1:0]   out_src;
    logic                  out_valid;
    logic                  out_ready;

    int tests = 0;
    int fails = 0;

    exp_t            exp_q[$];
    logic [WIDTH:0]  mem [SIZE][DEPTH];
    int              head [SIZE];
    int              len  [SIZE];
    logic [SIZE-1:0] gap;
    logic [SIZE-1:0] last_ack;

    mux_nto1_rr_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_last  (req_last),
        .in        (in),
        .ack       (ack),
        .grant     (grant),
        .out       (out),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue a packet on requester idx; the first n_exp flits are expected at the output.
    task automatic send(input int idx, input int n, input logic [WIDTH-1:0] base, input int n_exp);
        logic [WIDTH-1:0] d;
        logic             l;
        for (int k = 0; k < n; k++) begin
            d = base + k[WIDTH-1:0];
            l = (k == n - 1);
            mem[idx][len[idx]] = {l, d};
            len[idx]++;
            if (k < n_exp) exp_q.push_back({idx[LOG_SIZE-1:0], l, d});
        end
    endtask

    // One clock: present source heads, note ack before the edge, retire acked flits.
    task automatic tick();
        for (int i = 0; i < SIZE; i++) begin
            if (head[i] < len[i] && !gap[i]) begin
                req[i]               = 1'b1;
                in[WIDTH*i +: WIDTH] = mem[i][head[i]][WIDTH-1:0];
                req_last[i]          = mem[i][head[i]][WIDTH];
            end else begin
                req[i]      = 1'b0;
                req_last[i] = 1'b0;
            end
        end
        #1;
        last_ack = ack;
        @(posedge clock);
        #1;
        for (int i = 0; i < SIZE; i++) begin
            if (last_ack[i]) head[i]++;
        end
        @(negedge clock);
    endtask

    // Monitor: compares each accepted output flit and the ack invariants every cycle.
    always begin
        exp_t e;
        @(negedge clock);
        #2;
        check("ack_invariant",
              32'($onehot0(ack) && ((ack & ~grant) == {SIZE{1'b0}})), 32'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_flit: got src=%0d last=%0b data=0x%0h, expected none",
                         out_src, out_last, out);
            end else begin
                e = exp_q.pop_front();
                check("flit{src,last,data}", 32'({out_src, out_last, out}), 32'(e));
            end
        end
    end

    initial begin
        clock     = 1'b0;
        reset     = 1'b1;
        out_ready = 1'b1;
        gap       = {SIZE{1'b0}};
        req       = {SIZE{1'b0}};
        req_last  = {SIZE{1'b0}};
        in        = {(WIDTH*SIZE){1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end

        // Reset with every requester holding a single-flit packet; then fairness sweep.
        for (int i = 0; i < SIZE; i++) send(i, 1, 4'(i + 1), 1);
        send(0, 1, 4'h9, 1);
        tick();
        tick();
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_ptr", 32'(dut.ptr_r), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_ack", 32'(last_ack), 32'd0);
        reset = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (t % 2 == 1) check("rr_grant", 32'(grant), 32'(1) << (((t - 1) / 2) % SIZE));
            else            check("rr_bubble", 32'(grant), 32'd0);
        end
        check("rr_ptr", 32'(dut.ptr_r), 32'd1);

        // Packet lock: 4-flit packet on 3 while 5 waits.
        send(3, 4, 4'hA, 4);
        send(5, 1, 4'hE, 1);
        tick();
        check("lock_grant3", 32'(grant), 32'h08);
        for (int t = 0; t < 3; t++) begin
            tick();
            check("lock_hold3", 32'(grant), 32'h08);
        end
        tick();
        check("lock_release", 32'(grant), 32'd0);
        check("lock_ptr4", 32'(dut.ptr_r), 32'd4);
        tick();
        check("lock_grant5", 32'(grant), 32'h20);
        tick();
        check("lock_ptr6", 32'(dut.ptr_r), 32'd6);

        // Wrap-around from ptr=6 with a request gap mid-packet on 7.
        send(7, 3, 4'h1, 3);
        send(2, 1, 4'h5, 1);
        tick();
        check("wrap_grant7", 32'(grant), 32'h80);
        tick();
        gap[7] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick();
            check("gap_no_ack", 32'(last_ack), 32'd0);
            check("gap_lock_held", 32'(grant), 32'h80);
        end
        gap[7] = 1'b0;
        tick();
        check("gap_resume_ack", 32'(last_ack), 32'h80);
        tick();
        check("wrap_ptr0", 32'(dut.ptr_r), 32'd0);
        tick();
        check("wrap_grant2", 32'(grant), 32'h04);
        tick();
        check("wrap_ptr3", 32'(dut.ptr_r), 32'd3);

        // Backpressure: out_ready low for three cycles mid-packet on requester 1.
        send(1, 4, 4'h6, 4);
        tick();
        check("bp_grant1", 32'(grant), 32'h02);
        tick();
        tick();
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("bp_no_ack", 32'(last_ack), 32'd0);
            check("bp_out_hold", 32'(out), 32'h7);
            check("bp_last_hold", 32'(out_last), 32'd0);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_resume_ack", 32'(last_ack), 32'h02);
        tick();
        check("bp_ptr2", 32'(dut.ptr_r), 32'd2);

        // Reset during the second flit of a locked packet, then restart the packet.
        send(4, 3, 4'hC, 1);
        tick();
        check("mid_grant4", 32'(grant), 32'h10);
        tick();
        reset = 1'b1;
        tick();
        check("mid_reset_grant", 32'(grant), 32'd0);
        check("mid_reset_valid", 32'(out_valid), 32'd0);
        check("mid_reset_ptr", 32'(dut.ptr_r), 32'd0);
        head[4] = len[4];
        reset   = 1'b0;
        tick();
        check("post_reset_ack", 32'(last_ack), 32'd0);
        check("post_reset_grant", 32'(grant), 32'd0);
        send(4, 2, 4'h3, 2);
        tick();
        check("restart_grant4", 32'(grant), 32'h10);
        for (int t = 0; t < 4; t++) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
